// File: rtl/buck_pwm_pkg.sv
// buck_pwm_pkg: shared timing constants, state encoding and on-time clamp
package buck_pwm_pkg;
  localparam logic [15:0] PERIOD   = 16'd400;
  localparam logic [15:0] MAX_ON   = 16'd200;
  localparam logic [15:0] MIN_ON   = 16'd4;
  localparam logic [15:0] DEADTIME = 16'd10;
  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, FAULT = 2'd3} pwm_state_t;
  function automatic logic [15:0] clamp_on(input logic [15:0] t);
    return t > MAX_ON ? MAX_ON : (t < MIN_ON ? 16'd0 : t);
  endfunction
endpackage

// File: rtl/buck_pwm_channel.sv
// buck_pwm_channel: per-period on-time shadow and dead-timed complementary gate drive
module buck_pwm_channel
  import buck_pwm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [15:0] timer,
  input  logic [15:0] charging_time,
  output logic        hs,
  output logic        ls
);
  logic [15:0] shadow;
  logic [16:0] ls_start;
  assign ls_start = {1'b0, shadow} + {1'b0, DEADTIME};
  // latch the clamped request on the last cycle so each period uses one stable on-time
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) shadow <= '0;
    else if (timer == PERIOD - 16'd1) shadow <= clamp_on(charging_time);
  // hs/ls windows are disjoint by construction: ls starts DEADTIME after hs ends
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hs <= 1'b0;
      ls <= 1'b0;
    end else begin
      hs <= run && (timer < shadow);
      ls <= run && ({1'b0, timer} >= ls_start) && (timer < PERIOD - DEADTIME);
    end
endmodule

// File: rtl/buck_pwm_generator.sv
// buck_pwm_generator: switching-period timer, 180-degree phase offset and enable/fault FSM for two buck channels
module buck_pwm_generator
  import buck_pwm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fault,
  input  logic        fault_clear,
  input  logic [15:0] charging_time_0,
  input  logic [15:0] charging_time_1,
  output logic [15:0] timer_buck_4us_0,
  output logic [15:0] timer_buck_4us_1,
  output logic        mos_hs_0,
  output logic        mos_hs_1,
  output logic        mos_ls_0,
  output logic        mos_ls_1,
  output logic [1:0]  pwm_state
);
  pwm_state_t  state;
  logic [15:0] t0_next, t1_next;
  logic        run;
  assign t0_next   = (timer_buck_4us_0 == PERIOD - 16'd1) ? 16'd0 : timer_buck_4us_0 + 16'd1;
  assign t1_next   = (t0_next >= PERIOD / 2) ? t0_next - PERIOD / 2 : t0_next + PERIOD / 2;
  assign run       = (state == RUN) && enable && !fault;
  assign pwm_state = state;
  // free-running period counters; timer_1 is derived from the same next value so both stay in lockstep
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      timer_buck_4us_0 <= '0;
      timer_buck_4us_1 <= '0;
    end else begin
      timer_buck_4us_0 <= t0_next;
      timer_buck_4us_1 <= t1_next;
    end
  // fault overrides everything; ARM waits for the wrap so the first pulse is a whole period
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else if (fault) state <= FAULT;
    else
      case (state)
        IDLE:    state <= enable ? ARM : IDLE;
        ARM:     state <= !enable ? IDLE : (timer_buck_4us_0 == PERIOD - 16'd1) ? RUN : ARM;
        RUN:     state <= enable ? RUN : IDLE;
        FAULT:   state <= fault_clear ? IDLE : FAULT;
        default: state <= IDLE;
      endcase
  buck_pwm_channel u_ch0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .timer         (timer_buck_4us_0),
    .charging_time (charging_time_0),
    .hs            (mos_hs_0),
    .ls            (mos_ls_0)
  );
  buck_pwm_channel u_ch1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .timer         (timer_buck_4us_1),
    .charging_time (charging_time_1),
    .hs            (mos_hs_1),
    .ls            (mos_ls_1)
  );
endmodule
